// File: rtl/apb_reg_slave.sv
// APB slave bridging byte transfers onto an 8-entry register file.
// Define APB_WAIT_STATE_EN to insert WAIT_CYCLES wait states per transfer.
module apb_reg_slave #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic       reg_write_en,
  output logic [2:0] reg_write_addr,
  output logic [7:0] reg_write_data,
  output logic [2:0] reg_read_addr,
  input  logic [7:0] reg_read_data
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be within 1..15");
  end

`ifdef APB_WAIT_STATE_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  logic [3:0] cnt_q, cnt_d;
`else
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_READY = 1'b1
  } state_e;
`endif

  state_e     state_q, state_d;
  logic [2:0] addr_q, addr_d;
  logic       err_q, err_d;
  logic       wr_q, wr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] prdata_q, prdata_d;
  logic       pready_q, pready_d;
  logic       pslverr_q, pslverr_d;

  logic       setup;
  logic       oor_now;

  assign setup   = psel & ~penable;
  assign oor_now = |paddr[7:3];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    err_d     = err_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
`ifdef APB_WAIT_STATE_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (setup) begin
          addr_d  = paddr[2:0];
          err_d   = oor_now;
          wr_d    = pwrite;
          wdata_d = pwdata;
`ifdef APB_WAIT_STATE_EN
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
`else
          state_d   = S_READY;
          pready_d  = 1'b1;
          pslverr_d = oor_now;
          if (!pwrite)
            prdata_d = oor_now ? 8'h00 : reg_read_data;
`endif
        end
      end
`ifdef APB_WAIT_STATE_EN
      S_WAIT: begin
        if (!psel) begin
          // master abandoned the transfer
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d   = S_READY;
          cnt_d     = 4'd0;
          pready_d  = 1'b1;
          pslverr_d = err_q;
          if (!wr_q)
            prdata_d = err_q ? 8'h00 : reg_read_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      S_READY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= 3'd0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= 8'h00;
      prdata_q  <= 8'h00;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
`ifdef APB_WAIT_STATE_EN
      cnt_q     <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
`ifdef APB_WAIT_STATE_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign prdata         = prdata_q;
  assign pready         = pready_q;
  assign pslverr        = pslverr_q;
  assign reg_write_en   = pready_q & wr_q & ~err_q;
  assign reg_write_addr = addr_q;
  assign reg_write_data = wdata_q;
  assign reg_read_addr  = paddr[2:0];

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 Parameter: WAIT_CYCLES, 2, number of inserted APB wait states (legal 1..15), used only when APB_WAIT_STATE_EN is defined.
REQ-002 Port: clk  input  1  single clock; every state element updates on posedge clk.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: psel  input  1  APB select.
REQ-005 Port: penable  input  1  APB enable (access phase).
REQ-006 Port: pwrite  input  1  1 = write, 0 = read.
REQ-007 Port: paddr  input  8  byte address; legal range 0x00..0x07.
REQ-008 Port: pwdata  input  8  write data.
REQ-009 Port: prdata  output  8  read data, registered.
REQ-010 Port: pready  output  1  transfer-complete strobe, registered.
REQ-011 Port: pslverr  output  1  error response, registered, valid only while pready=1.
REQ-012 Port: reg_write_en  output  1  register-file write strobe.
REQ-013 Port: reg_write_addr  output  3  register-file write index.
REQ-014 Port: reg_write_data  output  8  register-file write data.
REQ-015 Port: reg_read_addr  output  3  register-file read index; combinational, equal to paddr[2:0].
REQ-016 Port: reg_read_data  input  8  combinational read data returned by the register file.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and READY.
REQ-018 IDLE: a sampled psel=1 with penable=0 SHALL latch paddr, pwrite and pwdata and move to READY (zero-wait build) or to WAIT with its counter loaded to WAIT_CYCLES.
REQ-019 IDLE: psel=1 with penable=1 and no preceding setup phase SHALL be ignored, producing no pready and no write.
REQ-020 WAIT: the counter SHALL decrement once per cycle, and the FSM SHALL move to READY on the edge where the counter equals 1.
REQ-021 READY: pready=1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-022 Latency: pready SHALL rise WAIT_CYCLES+1 cycles after the setup cycle (1 cycle in the zero-wait build).
REQ-023 Write, in-range: reg_write_en=1 SHALL be asserted in the same cycle as pready, with reg_write_addr/reg_write_data taken from the latched values, so the register file updates at the edge that ends the pready cycle.
REQ-024 Read, in-range: prdata SHALL capture reg_read_data on the edge that raises pready and hold that value until the next completed read.
REQ-025 Out-of-range (paddr[7:3] != 0): pslverr=1 during the pready cycle, reg_write_en SHALL stay 0, and prdata SHALL be 0x00.
REQ-026 Abort: psel=0 sampled in WAIT SHALL send the FSM to IDLE with no pready, no write and prdata unchanged.
REQ-027 Back-to-back: a new setup phase in the cycle following pready SHALL be accepted, giving no dead cycle beyond the IDLE sampling cycle.
REQ-028 Outside the pready cycle, reg_write_en and pslverr SHALL both be 0.

Reset
REQ-029 While rst=1, regardless of clk: FSM = IDLE, counter = 0, prdata = 0x00, pready = 0, pslverr = 0, reg_write_en = 0, and latched address/data = 0.
REQ-030 Reset asserted mid-transfer SHALL abort it with no write; after deassertion, the first accepted transfer SHALL be the next full setup phase.

Configuration
REQ-031 Macro APB_WAIT_STATE_EN defined: the WAIT state and counter SHALL be built, and every transfer SHALL carry WAIT_CYCLES wait states.
REQ-032 Macro APB_WAIT_STATE_EN undefined: the WAIT state SHALL be absent, WAIT_CYCLES ignored, and pready SHALL rise in the first access cycle.

Verification
REQ-033 Zero-wait write: paddr=0x03, pwdata=0xA5 -> pready=1 one cycle after setup, reg_write_en=1 with addr=3 and data=0xA5, pslverr=0.
REQ-034 Read-after-write: write 0x3C to 0x05, then read 0x05 -> prdata=0x3C during the read's pready cycle.
REQ-035 Error: write to paddr=0x10 -> pslverr=1 with pready=1 and reg_write_en=0; a subsequent read of paddr=0x10 -> prdata=0x00 and pslverr=1.
REQ-036 Wait states (macro defined, WAIT_CYCLES=3): write to 0x07 -> pready low for 3 access cycles and high on the 4th, with exactly one reg_write_en pulse.
REQ-037 Abort and reset: drop psel during WAIT -> no pready and no write; assert rst mid-WAIT -> all outputs 0 immediately, and the next full transfer completes normally.
REQ-038 Back-to-back: writes to 0x01, then 0x02, then a read of 0x01 with no idle gaps between transfers -> three pready pulses, and correct data in each.
